// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD,
      S_DROP
   } fetch_state_t;

   localparam logic [31:0] NOP_INST = 32'h0;
   localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating 32-bit event counter used by the fetch stage performance monitors.
module fetch_perf_ctr (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   // Sticks at all-ones instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the I-mem req/ack handshake and feeds IF/ID.
// Define FETCH_PERF_EN to build the fetched/dropped saturating counters; otherwise they read 0.
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_rdata_i,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] pc_o,
   output logic            valid_o,
   output logic [31:0]     perf_fetch_o,
   output logic [31:0]     perf_drop_o
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [31:0]     inst_q, inst_d;
   logic [XLEN-1:0] pc_out_q, pc_out_d;
   logic            valid_q, valid_d;

   logic [XLEN-1:0] redirect_tgt;
   logic            consume;

   assign redirect_tgt = redirect_pc_i & ~XLEN'(3);
   assign consume      = valid_q & ~stall_i & ~redirect_i;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      inst_d     = inst_q;
      pc_out_d   = pc_out_q;
      valid_d    = valid_q;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_WAIT;
            if (redirect_i) pc_d = redirect_tgt;
         end
         S_WAIT: begin
            // Remember the address on the bus in case a redirect turns this into S_DROP.
            req_addr_d = pc_q;
            if (redirect_i) begin
               pc_d    = redirect_tgt;
               state_d = imem_ack_i ? S_WAIT : S_DROP;
            end else if (imem_ack_i) begin
               inst_d   = imem_rdata_i;
               pc_out_d = pc_q;
               valid_d  = 1'b1;
               state_d  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect_i) begin
               pc_d     = redirect_tgt;
               valid_d  = 1'b0;
               inst_d   = NOP_INST;
               pc_out_d = '0;
               state_d  = S_WAIT;
            end else if (consume) begin
               pc_d     = pc_out_q + XLEN'(PC_STEP);
               valid_d  = 1'b0;
               inst_d   = NOP_INST;
               pc_out_d = '0;
               state_d  = S_WAIT;
            end
         end
         S_DROP: begin
            if (redirect_i) pc_d = redirect_tgt;
            if (imem_ack_i) state_d = S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= '0;
         inst_q     <= NOP_INST;
         pc_out_q   <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         inst_q     <= inst_d;
         pc_out_q   <= pc_out_d;
         valid_q    <= valid_d;
      end
   end

   // An abandoned-by-redirect request keeps its original address until memory acks it.
   assign imem_req_o  = (state_q == S_WAIT) || (state_q == S_DROP);
   assign imem_addr_o = (state_q == S_DROP) ? req_addr_q : pc_q;
   assign inst_o      = inst_q;
   assign pc_o        = pc_out_q;
   assign valid_o     = valid_q;

`ifdef FETCH_PERF_EN
   logic drop_evt;

   assign drop_evt = ((state_q == S_HOLD) & redirect_i)
                   | ((state_q == S_DROP) & imem_ack_i)
                   | ((state_q == S_WAIT) & imem_ack_i & redirect_i);

   fetch_perf_ctr u_fetch_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (consume),
      .count_o (perf_fetch_o)
   );

   fetch_perf_ctr u_drop_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (drop_evt),
      .count_o (perf_drop_o)
   );
`else
   assign perf_fetch_o = '0;
   assign perf_drop_o  = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit; a second instance covers RESET_PC wrap-around.
module tb_if_fetch_unit;

`ifdef FETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] rpc;
   logic        auto_ack;
   logic        man_ack;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        valid;
   logic [31:0] perf_fetch;
   logic [31:0] perf_drop;

   logic        req_w;
   logic [31:0] addr_w;
   logic [31:0] rdata_w;
   logic [31:0] inst_w;
   logic [31:0] pc_w;
   logic        valid_w;
   logic [31:0] perf_fetch_w;
   logic [31:0] perf_drop_w;
   logic        zero_bit = 1'b0;
   logic [31:0] zero_word = 32'h0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rd(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   assign imem_rdata = rd(imem_addr);
   assign imem_ack   = auto_ack ? imem_req : man_ack;
   assign rdata_w    = rd(addr_w);

   if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (rpc),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ack_i    (imem_ack),
      .imem_rdata_i  (imem_rdata),
      .inst_o        (inst),
      .pc_o          (pc),
      .valid_o       (valid),
      .perf_fetch_o  (perf_fetch),
      .perf_drop_o   (perf_drop)
   );

   if_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk_i         (clk),
      .rst_i         (rst),
      .stall_i       (zero_bit),
      .redirect_i    (zero_bit),
      .redirect_pc_i (zero_word),
      .imem_req_o    (req_w),
      .imem_addr_o   (addr_w),
      .imem_ack_i    (req_w),
      .imem_rdata_i  (rdata_w),
      .inst_o        (inst_w),
      .pc_o          (pc_w),
      .valid_o       (valid_w),
      .perf_fetch_o  (perf_fetch_w),
      .perf_drop_o   (perf_drop_w)
   );

   // Address is only meaningful while req is high, so it is masked otherwise.
   function automatic logic [97:0] obs();
      return {imem_req, imem_req ? imem_addr : 32'h0, valid, pc, inst};
   endfunction

   function automatic logic [97:0] obs_w();
      return {req_w, req_w ? addr_w : 32'h0, valid_w, pc_w, inst_w};
   endfunction

   function automatic logic [97:0] ex(input logic r, input logic [31:0] a, input logic v,
                                      input logic [31:0] p, input logic [31:0] i);
      return {r, a, v, p, i};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = 32'h0;
      auto_ack = 1'b0; man_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [97:0] e;
      do_reset();
      e = ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs(), e); end
      n_checks++;
      if ({perf_fetch, perf_drop} !== 64'h0) begin
         n_fail++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetch, perf_drop);
      end
   endtask

   task automatic test_same_cycle_ack();
      logic [97:0] e;
      do_reset();
      auto_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         e = ex(1'b1, 32'(4 * k), 1'b0, 32'h0, 32'h0);
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL sca_req%0d: got %h want %h", k, obs(), e); end
         tick();
         e = ex(1'b0, 32'h0, 1'b1, 32'(4 * k), rd(32'(4 * k)));
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL sca_valid%0d: got %h want %h", k, obs(), e); end
      end
   endtask

   task automatic test_delayed_ack();
      logic [97:0] e;
      do_reset();
      auto_ack = 1'b1;
      tick();
      tick();
      auto_ack = 1'b0;
      tick();
      e = ex(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL delay_wait%0d: got %h want %h", i, obs(), e); end
         tick();
      end
      man_ack = 1'b1;
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL delay_ack_cycle: got %h want %h", obs(), e); end
      tick();
      man_ack = 1'b0;
      e = ex(1'b0, 32'h0, 1'b1, 32'h4, rd(32'h4));
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL delay_valid: got %h want %h", obs(), e); end
   endtask

   task automatic test_stall();
      logic [97:0] e;
      stall = 1'b1;
      e = ex(1'b0, 32'h0, 1'b1, 32'h4, rd(32'h4));
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, obs(), e); end
      end
      stall = 1'b0;
      auto_ack = 1'b1;
      tick();
      e = ex(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL stall_release: got %h want %h", obs(), e); end
      stall = 1'b1;
      tick();
      e = ex(1'b0, 32'h0, 1'b1, 32'h8, rd(32'h8));
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL stall_no_valid: got %h want %h", obs(), e); end
      n_checks++;
      if (perf_fetch !== (PERF ? 32'd2 : 32'd0)) begin
         n_fail++; $display("FAIL stall_perf_fetch: got %0d want %0d", perf_fetch, PERF ? 2 : 0);
      end
      stall = 1'b0;
      auto_ack = 1'b0;
   endtask

   task automatic test_redirect_wait();
      logic [97:0] e;
      do_reset();
      tick();
      redirect = 1'b1;
      rpc = 32'h103;
      tick();
      redirect = 1'b0;
      e = ex(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL rdw_old_addr%0d: got %h want %h", i, obs(), e); end
         tick();
      end
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      e = ex(1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL rdw_target: got %h want %h", obs(), e); end
      n_checks++;
      if (perf_drop !== (PERF ? 32'd1 : 32'd0)) begin
         n_fail++; $display("FAIL rdw_perf_drop: got %0d want %0d", perf_drop, PERF ? 1 : 0);
      end
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      e = ex(1'b0, 32'h0, 1'b1, 32'h100, rd(32'h100));
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL rdw_fetch: got %h want %h", obs(), e); end
   endtask

   task automatic test_redirect_hold();
      logic [97:0] e;
      do_reset();
      auto_ack = 1'b1;
      tick();
      tick();
      auto_ack = 1'b0;
      stall = 1'b1;
      redirect = 1'b1;
      rpc = 32'h200;
      tick();
      redirect = 1'b0;
      stall = 1'b0;
      e = ex(1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL rdh_flush: got %h want %h", obs(), e); end
      n_checks++;
      if ({perf_fetch, perf_drop} !== {32'd0, PERF ? 32'd1 : 32'd0}) begin
         n_fail++; $display("FAIL rdh_perf: got %0d/%0d want 0/%0d", perf_fetch, perf_drop, PERF ? 1 : 0);
      end
      auto_ack = 1'b1;
      redirect = 1'b1;
      rpc = 32'h300;
      tick();
      redirect = 1'b0;
      e = ex(1'b1, 32'h300, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL rdh_ack_redirect: got %h want %h", obs(), e); end
      n_checks++;
      if (perf_drop !== (PERF ? 32'd2 : 32'd0)) begin
         n_fail++; $display("FAIL rdh_perf_drop2: got %0d want %0d", perf_drop, PERF ? 2 : 0);
      end
      tick();
      e = ex(1'b0, 32'h0, 1'b1, 32'h300, rd(32'h300));
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL rdh_refetch: got %h want %h", obs(), e); end
      tick();
      e = ex(1'b1, 32'h304, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL rdh_next: got %h want %h", obs(), e); end
      n_checks++;
      if (perf_fetch !== (PERF ? 32'd1 : 32'd0)) begin
         n_fail++; $display("FAIL rdh_perf_fetch: got %0d want %0d", perf_fetch, PERF ? 1 : 0);
      end
      auto_ack = 1'b0;
   endtask

   task automatic test_wrap_and_reset();
      logic [97:0] e;
      do_reset();
      tick();
      e = ex(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (obs_w() !== e) begin n_fail++; $display("FAIL wrap_first: got %h want %h", obs_w(), e); end
      tick();
      e = ex(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, rd(32'hFFFF_FFFC));
      n_checks++;
      if (obs_w() !== e) begin n_fail++; $display("FAIL wrap_valid: got %h want %h", obs_w(), e); end
      tick();
      e = ex(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (obs_w() !== e) begin n_fail++; $display("FAIL wrap_second: got %h want %h", obs_w(), e); end
      redirect = 1'b1;
      rpc = 32'h400;
      tick();
      redirect = 1'b0;
      e = ex(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL rst_drop_entry: got %h want %h", obs(), e); end
      rst = 1'b1;
      tick();
      e = ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL rst_mid_drop: got %h want %h", obs(), e); end
      rst = 1'b0;
      tick();
      e = ex(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL rst_restart_pc: got %h want %h", obs(), e); end
      n_checks++;
      if (perf_drop !== 32'd0) begin n_fail++; $display("FAIL rst_perf_drop: got %0d want 0", perf_drop); end
   endtask

   initial begin
      test_reset();
      test_same_cycle_ack();
      test_delayed_ack();
      test_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_wrap_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
